// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the iterative restoring divider:
//   - FSM state encoding (enum plus plain localparam constants for legacy users)
//   - counter width helper and divider latency helper
// No ports (package).
// -----------------------------------------------------------------------------
package seq_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Bits needed to count WIDTH-1 down to 0 (WIDTH >= 2, so never below 1).
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

   // Edges from operand accept to out_valid for a non-zero divisor.
   function automatic int div_latency(input int w);
      return w;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// seq_divider_div_step
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
// Ports:
//   i_prem    [WIDTH:0]   current partial remainder
//   i_bit                 next dividend bit (MSB first)
//   i_divisor [WIDTH-1:0] divisor
//   o_prem    [WIDTH:0]   next partial remainder
//   o_qbit                quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module seq_divider_div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   i_prem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_prem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_div_ext;
   logic           w_unused_top;

   // The incoming remainder is always < divisor, so its top bit is zero and
   // dropping it in the shift loses nothing; the extra bit exists so that the
   // shifted value can reach 2*D-1 for divisors >= 2^(WIDTH-1).
   assign w_unused_top = i_prem[WIDTH];
   assign w_shift      = {i_prem[WIDTH-1:0], i_bit};
   assign w_div_ext    = {1'b0, i_divisor};
   assign o_qbit       = (w_shift >= w_div_ext);
   assign o_prem       = o_qbit ? (w_shift - w_div_ext) : w_shift;

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional signed mode: define SEQ_DIVIDER_SIGNED_EN to add the signed_op port
// (two's complement operands, quotient truncated toward zero, remainder takes
// the dividend's sign).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE, out_valid only in DONE, so an operand
// accept and a result release can never share an edge. Once out_valid is high
// the result stays stable until the release edge.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake
//   dividend, divisor       operands N, D (WIDTH bits)
//   signed_op               (SEQ_DIVIDER_SIGNED_EN only) operands are signed
//   out_valid / out_ready   result handshake
//   quotient, remainder     N / D, N mod D
//   div_by_zero             result came from D == 0
//   busy                    high in CALC or DONE
//   o_state                 FSM state (debug)
// -----------------------------------------------------------------------------
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
   input  logic             signed_op,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy,
   output logic [1:0]       o_state
);

   localparam int              CNT_W       = cnt_width(WIDTH);
   localparam int              DIV_LATENCY = div_latency(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DIV_LATENCY - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH:0]   r_p;
   logic             r_dbz;

   logic             w_accept;
   logic             w_release;
   logic [WIDTH-1:0] w_n_mag;
   logic [WIDTH-1:0] w_d_mag;
   logic [WIDTH:0]   w_p_next;
   logic             w_qbit;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   assign in_ready    = (r_state == S_IDLE);
   assign out_valid   = (r_state == S_DONE);
   assign busy        = (r_state != S_IDLE);
   assign o_state     = r_state;
   assign quotient    = r_q;
   assign remainder   = r_p[WIDTH-1:0];
   assign div_by_zero = r_dbz;

   assign w_accept  = in_valid && in_ready;
   assign w_release = out_valid && out_ready;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;
   logic w_n_neg;
   logic w_d_neg;

   assign w_n_neg = signed_op && dividend[WIDTH-1];
   assign w_d_neg = signed_op && divisor[WIDTH-1];
   // The core only ever sees magnitudes; -MIN wraps to MIN, which is the
   // correct unsigned magnitude.
   assign w_n_mag = w_n_neg ? (~dividend + 1'b1) : dividend;
   assign w_d_mag = w_d_neg ? (~divisor + 1'b1) : divisor;
   // Sign fix-up is folded into the final CALC edge so latency is unchanged.
   // MIN / -1 naturally yields MIN with remainder 0.
   assign w_q_fin = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
   assign w_r_fin = r_neg_r ? (~w_p_next[WIDTH-1:0] + 1'b1) : w_p_next[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_q <= w_n_neg ^ w_d_neg;
         r_neg_r <= w_n_neg;
      end
   end
`else
   assign w_n_mag = dividend;
   assign w_d_mag = divisor;
   assign w_q_fin = w_q_next;
   assign w_r_fin = w_p_next[WIDTH-1:0];
`endif

   seq_divider_div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .i_prem    (r_p),
      .i_bit     (r_n[r_cnt]),
      .i_divisor (r_d),
      .o_prem    (w_p_next),
      .o_qbit    (w_qbit)
   );

   always_comb begin
      w_q_next        = r_q;
      w_q_next[r_cnt] = w_qbit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_n     <= '0;
         r_d     <= '0;
         r_q     <= '0;
         r_p     <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_n <= w_n_mag;
                  r_d <= w_d_mag;
                  if (divisor == '0) begin
                     // Divide by zero: publish immediately, remainder = N as given.
                     r_q     <= '1;
                     r_p     <= {1'b0, dividend};
                     r_dbz   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_q     <= '0;
                     r_p     <= '0;
                     r_dbz   <= 1'b0;
                     r_cnt   <= CNT_MAX;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (r_cnt == '0) begin
                  r_q     <= w_q_fin;
                  r_p     <= {1'b0, w_r_fin};
                  r_state <= S_DONE;
               end else begin
                  r_q   <= w_q_next;
                  r_p   <= w_p_next;
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (w_release) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider at WIDTH=16 with hand-computed expectations.
// Signed cases are included when SEQ_DIVIDER_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic         signed_op;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         busy;
   logic [1:0]   o_state;

   int n_checks = 0;
   int n_errs   = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .busy        (busy),
      .o_state     (o_state)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands at a falling edge; the accept happens on the next rising edge.
   task automatic accept(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
      @(negedge clk);
      in_valid = 1'b1;
      dividend = n;
      divisor  = d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      signed_op = s;
`else
      if (s) $display("note: signed request ignored in unsigned build");
`endif
      check("in_ready_pre_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count rising edges after the accept edge until out_valid (bounded).
   task automatic wait_result(output int edges);
      edges = 0;
      while (out_valid !== 1'b1 && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   // Full transaction with out_ready already high: result, then release.
   task automatic run_div(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                          input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input int elat);
      int e;
      accept(n, d, s);
      wait_result(e);
      check({tag, "_latency"}, e, elat);
      check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
      check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, er});
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
      check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_released_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_released_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int e;
      // reset
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
      signed_op = 1'b0;
`endif
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_quotient", {16'd0, quotient}, 32'd0);
      check("rst_remainder", {16'd0, remainder}, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_state", {30'd0, o_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic, wide divisor, divide by zero, boundaries
      run_div("basic",   16'd1000, 16'd7,      1'b0, 16'd142,    16'd6,      1'b0, 16);
      run_div("wide",    16'hFFFF, 16'h8001,   1'b0, 16'd1,      16'h7FFE,   1'b0, 16);
      run_div("dbz",     16'd5,    16'd0,      1'b0, 16'hFFFF,   16'd5,      1'b1, 0);
      run_div("max_d1",  16'hFFFF, 16'd1,      1'b0, 16'hFFFF,   16'd0,      1'b0, 16);
      run_div("small_n", 16'd3,    16'hFFFF,   1'b0, 16'd0,      16'd3,      1'b0, 16);
      run_div("zero_n",  16'd0,    16'd5,      1'b0, 16'd0,      16'd0,      1'b0, 16);
      run_div("d_eq_n",  16'd12345,16'd12345,  1'b0, 16'd1,      16'd0,      1'b0, 16);

      // backpressure: result held, in_ready low, extra operands ignored
      out_ready = 1'b0;
      accept(16'd100, 16'd10, 1'b0);
      wait_result(e);
      check("bp_latency", e, 16);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = 16'd7;
         divisor  = 16'd7;
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_quotient", {16'd0, quotient}, 32'd10);
         check("bp_remainder", {16'd0, remainder}, 32'd0);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_still_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
      check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
      check("bp_q_kept", {16'd0, quotient}, 32'd10);

      // reset in the middle of CALC
      accept(16'd1000, 16'd3, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_state", {30'd0, o_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_div("after_rst", 16'd81, 16'd9, 1'b0, 16'd9, 16'd0, 1'b0, 16);

`ifdef SEQ_DIVIDER_SIGNED_EN
      run_div("s_neg7_2",   16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 16);
      run_div("s_min_m1",   16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0,    1'b0, 16);
      run_div("s_7_neg2",   16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0, 16);
      run_div("s_dbz",      16'hFFF9, 16'd0,    1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 0);
      run_div("u_in_s_bld", 16'hFFF9, 16'd2,    1'b0, 16'h7FFC, 16'd1,    1'b0, 16);
`endif

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
